// File: rtl/pipe_pre_if.sv
// Pre-fetch stage: selects the next fetch PC, drives the instruction SRAM
// address and buffers redirects that arrive while IF is stalled.
module pipe_pre_if #(
   parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        from_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic [31:0] ex_entry,
   output logic        to_valid,
   output logic [31:0] nextpc,
   output logic        to_adef,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic        ex_buf_v;
   logic [31:0] ex_buf;
   logic        br_buf_v;
   logic [31:0] br_buf;
   logic        fire;

   // Live redirects beat buffered ones; exceptions beat branches.
   always_comb begin
      nextpc = pc_q + 32'd4;
      if (ex_flush)
         nextpc = ex_entry;
      else if (br_taken)
         nextpc = br_target;
      else if (ex_buf_v)
         nextpc = ex_buf;
      else if (br_buf_v)
         nextpc = br_buf;
   end

   // Gating with reset keeps the handshake quiet before valid_q has ever been clocked.
   assign to_valid       = valid_q && !reset;
   assign fire           = to_valid && from_allowin;
   assign to_adef        = |nextpc[1:0];
   assign inst_sram_en   = fire;
   assign inst_sram_addr = nextpc;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         pc_q     <= RESET_PC - 32'd4;
         ex_buf_v <= 1'b0;
         ex_buf   <= 32'd0;
         br_buf_v <= 1'b0;
         br_buf   <= 32'd0;
      end else begin
         valid_q <= 1'b1;
         if (fire) begin
            pc_q     <= nextpc;
            ex_buf_v <= 1'b0;
            br_buf_v <= 1'b0;
         end else if (ex_flush) begin
            // A flush squashes whatever branch was waiting behind the stall.
            ex_buf_v <= 1'b1;
            ex_buf   <= ex_entry;
            br_buf_v <= 1'b0;
         end else if (br_taken && !ex_buf_v) begin
            br_buf_v <= 1'b1;
            br_buf   <= br_target;
         end
      end
   end

endmodule

// File: tb/tb_pipe_pre_if.sv
// Scoreboard bench for pipe_pre_if: the driver queues expected fetch PCs,
// a monitor pops them whenever the SRAM enable fires.
module tb_pipe_pre_if;

   logic        clk = 1'b0;
   logic        reset;
   logic        from_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ex_flush;
   logic [31:0] ex_entry;
   logic        to_valid;
   logic [31:0] nextpc;
   logic        to_adef;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   pipe_pre_if #(.RESET_PC(32'h1C00_0000)) dut (
      .clk(clk), .reset(reset), .from_allowin(from_allowin),
      .br_taken(br_taken), .br_target(br_target),
      .ex_flush(ex_flush), .ex_entry(ex_entry),
      .to_valid(to_valid), .nextpc(nextpc), .to_adef(to_adef),
      .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every issued fetch must match the next queued expectation.
   always @(negedge clk) begin
      if (inst_sram_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fire: addr %h with empty scoreboard at %0t", inst_sram_addr, $time);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("fire_nextpc", nextpc, e);
            chk("fire_addr", inst_sram_addr, e);
            chk("fire_adef", {31'd0, to_adef}, {31'd0, |e[1:0]});
            chk("fire_valid", {31'd0, to_valid}, 32'd1);
         end
      end
   end

   // One cycle of stimulus, applied just after a rising edge.
   task automatic cyc(input logic allow, input logic br, input logic [31:0] bt,
                      input logic ex, input logic [31:0] ee,
                      input logic exp_fire, input logic [31:0] exp_pc);
      from_allowin = allow;
      br_taken     = br;
      br_target    = bt;
      ex_flush     = ex;
      ex_entry     = ee;
      if (exp_fire) exp_q.push_back(exp_pc);
      @(negedge clk);
      if (!exp_fire) begin
         chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
         chk("stall_nextpc", nextpc, exp_pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cyc(input logic allow);
      reset        = 1'b1;
      from_allowin = allow;
      br_taken     = 1'b0;
      ex_flush     = 1'b0;
      @(negedge clk);
      chk("reset_to_valid", {31'd0, to_valid}, 32'd0);
      chk("reset_sram_en", {31'd0, inst_sram_en}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; from_allowin = 1'b0; br_taken = 1'b0; br_target = '0;
      ex_flush = 1'b0; ex_entry = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_cyc(1'b1);
      // First cycle out of reset: valid not yet up, next PC is RESET_PC.
      cyc(1, 0, 0, 0, 0, 0, 32'h1C00_0000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0004);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0008);
      // Same-cycle branch.
      cyc(1, 1, 32'h1C00_0100, 0, 0, 1, 32'h1C00_0100);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0104);
      // Branch buffered across a stall.
      cyc(0, 1, 32'h1C00_0200, 0, 0, 0, 32'h1C00_0200);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 32'h1C00_0200);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0200);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0204);
      // Buffered branch killed by a later flush.
      cyc(0, 1, 32'h1C00_0300, 0, 0, 0, 32'h1C00_0300);
      cyc(0, 0, 0, 1, 32'h1C00_8000, 0, 32'h1C00_8000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_8000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_8004);
      // Simultaneous flush and branch: exception wins, branch dropped.
      cyc(1, 1, 32'h1C00_0400, 1, 32'h1C00_8000, 1, 32'h1C00_8000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_8004);
      // Misaligned target is still issued, flagged by to_adef.
      cyc(1, 1, 32'h1C00_0402, 0, 0, 1, 32'h1C00_0402);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0406);
      cyc(1, 1, 32'h1C00_0410, 0, 0, 1, 32'h1C00_0410);
      // Branch while an exception is buffered is ignored.
      cyc(0, 0, 0, 1, 32'h1C00_9000, 0, 32'h1C00_9000);
      cyc(0, 1, 32'h1C00_0500, 0, 0, 0, 32'h1C00_0500);
      cyc(0, 0, 0, 0, 0, 0, 32'h1C00_9000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_9000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_9004);
      // Address wraps modulo 2^32.
      cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 0, 0, 1, 32'h0000_0000);
      // Reset in the middle of a stall discards the buffered branch.
      cyc(0, 1, 32'h1C00_0600, 0, 0, 0, 32'h1C00_0600);
      cyc(0, 0, 0, 0, 0, 0, 32'h1C00_0600);
      reset_cyc(1'b1);
      cyc(1, 0, 0, 0, 0, 0, 32'h1C00_0000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0000);
      cyc(1, 0, 0, 0, 0, 1, 32'h1C00_0004);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 32'h1C00_0008);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
